// File: rtl/mips_fetch_ctrl.sv
// mips_fetch_ctrl: IF-stage sequencer for the MIPS pipeline.
// Owns the PC, talks to instruction memory over a req/ack handshake,
// applies branch redirects from ID, honours ID stalls, and drives the
// IF/ID register outputs. A one-entry skid buffer absorbs an instruction
// that returns while ID is stalled, so no fetched word is ever lost.
module mips_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic [31:0] pc_branch,
    input  logic        stall_D,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction_F,
    output logic [31:0] pc_F,
    output logic [31:0] PcPlus4_F,
    output logic        valid_F,
    output logic        flush_D
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pcF_q, pcF_d;
    logic        valid_q, valid_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic        skidValid_q, skidValid_d;
    logic        flush_q, flush_d;

    logic        consume;
    logic [31:0] branchTarget;
    logic [31:0] pcPlus4;

    // The redirect target is forced to a word boundary; the fetch PC
    // advances by one word and simply wraps at the top of the address space.
    assign branchTarget = pc_branch & ~32'h0000_0003;
    assign pcPlus4      = pc_q + 32'd4;
    assign consume      = valid_q & ~stall_D;

    // A request is outstanding in FETCH and DRAIN; the address is the
    // internal PC, which only moves when an ack is taken, so it stays
    // stable for the whole life of a request.
    assign imem_req      = (state_q == FETCH) || (state_q == DRAIN);
    assign imem_addr     = pc_q;
    assign Instruction_F = instr_q;
    assign pc_F          = pcF_q;
    assign PcPlus4_F     = pcF_q + 32'd4;
    assign valid_F       = valid_q;
    assign flush_D       = flush_q;

    // Next-state and datapath decisions; every register holds by default
    // and a redirect from ID overrides all other activity in the cycle.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        instr_d     = instr_q;
        pcF_d       = pcF_q;
        valid_d     = valid_q;
        skidInstr_d = skidInstr_q;
        skidPc_d    = skidPc_q;
        skidValid_d = skidValid_q;
        flush_d     = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end

            FETCH: begin
                if (branch) begin
                    flush_d     = 1'b1;
                    valid_d     = 1'b0;
                    skidValid_d = 1'b0;
                    if (imem_ack) begin
                        pc_d = branchTarget;
                    end else begin
                        tgt_d   = branchTarget;
                        state_d = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_d = pcPlus4;
                    if (!valid_q || consume) begin
                        instr_d = imem_rdata;
                        pcF_d   = pc_q;
                        valid_d = 1'b1;
                    end else begin
                        skidInstr_d = imem_rdata;
                        skidPc_d    = pc_q;
                        skidValid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end else if (consume) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch) begin
                    flush_d     = 1'b1;
                    valid_d     = 1'b0;
                    skidValid_d = 1'b0;
                    pc_d        = branchTarget;
                    state_d     = FETCH;
                end else if (!stall_D) begin
                    instr_d     = skidInstr_q;
                    pcF_d       = skidPc_q;
                    valid_d     = 1'b1;
                    skidValid_d = 1'b0;
                    state_d     = FETCH;
                end
            end

            DRAIN: begin
                if (branch) begin
                    flush_d     = 1'b1;
                    valid_d     = 1'b0;
                    skidValid_d = 1'b0;
                    tgt_d       = branchTarget;
                end
                if (imem_ack) begin
                    pc_d    = branch ? branchTarget : tgt_q;
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and datapath registers; reset takes effect immediately so the
    // request drops in the same cycle reset is asserted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            tgt_q       <= 32'd0;
            instr_q     <= 32'd0;
            pcF_q       <= 32'd0;
            valid_q     <= 1'b0;
            skidInstr_q <= 32'd0;
            skidPc_q    <= 32'd0;
            skidValid_q <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            instr_q     <= instr_d;
            pcF_q       <= pcF_d;
            valid_q     <= valid_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
            skidValid_q <= skidValid_d;
            flush_q     <= flush_d;
        end
    end

endmodule
